// File: rtl/btle_rx_pdu_buffer_if.sv
// Replay stream from the PDU buffer to the host/MAC side: one octet per
// valid/ready handshake, with a last flag and the packet's CRC verdict.
interface btle_rx_pdu_buffer_if;
    logic [7:0] out_octet;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       out_crc_ok;

    // The buffer sources the stream.
    modport master (
        output out_octet,
        output out_valid,
        output out_last,
        output out_crc_ok,
        input  out_ready
    );

    // The host/MAC consumes the stream.
    modport slave (
        input  out_octet,
        input  out_valid,
        input  out_last,
        input  out_crc_ok,
        output out_ready
    );
endinterface

// File: rtl/btle_rx_pdu_buffer.sv
// BLE RX PDU buffer: captures each decoded packet's octets speculatively into
// a circular RAM, commits them on decode_end (CRC permitting) by pushing a
// {length, crc} descriptor, and replays committed packets over a valid/ready
// stream. Bad-CRC, overflowing or descriptor-starved packets roll back.
module btle_rx_pdu_buffer #(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DESC_WIDTH   = 3,
    parameter int unsigned DROP_BAD_CRC = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  octet,
    input  logic                        octet_valid,
    input  logic                        decode_end,
    input  logic                        crc_ok,
    btle_rx_pdu_buffer_if.master        out_if,
    output logic [7:0]                  pkt_count,
    output logic [7:0]                  drop_count
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned DDEPTH = 1 << DESC_WIDTH;

    localparam logic [ADDR_WIDTH:0] PTR_ONE  = 1;
    localparam logic [DESC_WIDTH:0] DPTR_ONE = 1;
    localparam logic [8:0]          LEN_ONE  = 9'd1;
    localparam logic [7:0]          CNT_ONE  = 8'd1;

    typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP}    w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} r_state_t;

    // ---------------- state ----------------
    w_state_t              w_state_q,    w_state_d;
    r_state_t              r_state_q,    r_state_d;
    logic [ADDR_WIDTH:0]   wr_spec_q,    wr_spec_d;
    logic [ADDR_WIDTH:0]   wr_commit_q,  wr_commit_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q,     rd_ptr_d;
    logic [8:0]            len_q,        len_d;
    logic [7:0]            pkt_count_q,  pkt_count_d;
    logic [7:0]            drop_count_q, drop_count_d;
    logic [DESC_WIDTH:0]   desc_wp_q,    desc_wp_d;
    logic [DESC_WIDTH:0]   desc_rp_q,    desc_rp_d;
    logic [8:0]            rem_q,        rem_d;
    logic                  crc_q,        crc_d;
    logic [7:0]            out_octet_q,  out_octet_d;
    logic                  out_valid_q,  out_valid_d;
    logic                  out_last_q,   out_last_d;
    logic                  out_crc_q,    out_crc_d;

    // ---------------- storage ----------------
    logic [7:0]            ram_mem [DEPTH];
    logic [7:0]            ram_rdata;
    logic [8:0]            desc_len_mem [DDEPTH];
    logic                  desc_crc_mem [DDEPTH];

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic                  desc_push;
    logic                  wr_overflow;

    // Full is judged against the registered read pointer, so space freed by a
    // read only becomes usable one cycle later.
    logic ram_full;
    logic desc_full;
    logic desc_empty;

    assign ram_full   = (wr_spec_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                        (wr_spec_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign desc_full  = (desc_wp_q[DESC_WIDTH] != desc_rp_q[DESC_WIDTH]) &&
                        (desc_wp_q[DESC_WIDTH-1:0] == desc_rp_q[DESC_WIDTH-1:0]);
    assign desc_empty = (desc_wp_q == desc_rp_q);

    // Write side: speculative capture, then commit or roll back on decode_end.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default infers a latch.
    always_comb begin
        w_state_d    = w_state_q;
        wr_spec_d    = wr_spec_q;
        wr_commit_d  = wr_commit_q;
        len_d        = len_q;
        pkt_count_d  = pkt_count_q;
        drop_count_d = drop_count_q;
        desc_wp_d    = desc_wp_q;
        ram_we       = 1'b0;
        ram_waddr    = wr_spec_q[ADDR_WIDTH-1:0];
        desc_push    = 1'b0;
        wr_overflow  = 1'b0;

        case (w_state_q)
            W_IDLE: begin
                if (octet_valid) begin
                    if (ram_full) begin
                        w_state_d = W_DROP;
                    end else begin
                        ram_we    = 1'b1;
                        wr_spec_d = wr_spec_q + PTR_ONE;
                        len_d     = LEN_ONE;
                        w_state_d = W_RECV;
                    end
                end
            end

            W_RECV: begin
                if (octet_valid) begin
                    if (ram_full) begin
                        wr_overflow = 1'b1;
                    end else begin
                        ram_we    = 1'b1;
                        wr_spec_d = wr_spec_q + PTR_ONE;
                        len_d     = len_q + LEN_ONE;
                    end
                end
                if (decode_end) begin
                    if (!wr_overflow && (crc_ok || (DROP_BAD_CRC == 0)) && !desc_full) begin
                        desc_push   = 1'b1;
                        desc_wp_d   = desc_wp_q + DPTR_ONE;
                        wr_commit_d = wr_spec_d;
                        pkt_count_d = pkt_count_q + CNT_ONE;
                    end else begin
                        wr_spec_d = wr_commit_q;
                        if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + CNT_ONE;
                    end
                    w_state_d = W_IDLE;
                end else if (wr_overflow) begin
                    w_state_d = W_DROP;
                end
            end

            W_DROP: begin
                if (decode_end) begin
                    wr_spec_d = wr_commit_q;
                    if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + CNT_ONE;
                    w_state_d = W_IDLE;
                end
            end

            default: w_state_d = W_IDLE;
        endcase
    end

    // Read side: fetch one octet, present it, wait for handshake, repeat.
    // The descriptor slot is released only after the last octet is taken, so
    // the descriptor FIFO bounds the number of packets resident in the buffer.
    always_comb begin
        r_state_d   = r_state_q;
        rem_d       = rem_q;
        crc_d       = crc_q;
        rd_ptr_d    = rd_ptr_q;
        desc_rp_d   = desc_rp_q;
        out_octet_d = out_octet_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_crc_d   = out_crc_q;
        ram_re      = 1'b0;
        ram_raddr   = rd_ptr_q[ADDR_WIDTH-1:0];

        case (r_state_q)
            R_IDLE: begin
                if (!desc_empty) begin
                    rem_d     = desc_len_mem[desc_rp_q[DESC_WIDTH-1:0]];
                    crc_d     = desc_crc_mem[desc_rp_q[DESC_WIDTH-1:0]];
                    ram_re    = 1'b1;
                    r_state_d = R_FETCH;
                end
            end

            R_FETCH: begin
                out_octet_d = ram_rdata;
                out_valid_d = 1'b1;
                out_last_d  = (rem_q == LEN_ONE);
                out_crc_d   = crc_q;
                r_state_d   = R_STREAM;
            end

            R_STREAM: begin
                if (out_if.out_ready) begin
                    rd_ptr_d    = rd_ptr_q + PTR_ONE;
                    rem_d       = rem_q - LEN_ONE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (rem_q == LEN_ONE) begin
                        desc_rp_d = desc_rp_q + DPTR_ONE;
                        r_state_d = R_IDLE;
                    end else begin
                        ram_re    = 1'b1;
                        ram_raddr = rd_ptr_d[ADDR_WIDTH-1:0];
                        r_state_d = R_FETCH;
                    end
                end
            end

            default: r_state_d = R_IDLE;
        endcase
    end

    // Octet RAM and descriptor storage: plain synchronous memories.
    // NOTE: memories carry no reset; validity is defined entirely by the
    // pointers, which are reset, so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_we) ram_mem[ram_waddr] <= octet;
        if (ram_re) ram_rdata <= ram_mem[ram_raddr];
        if (desc_push) begin
            desc_len_mem[desc_wp_q[DESC_WIDTH-1:0]] <= len_d;
            desc_crc_mem[desc_wp_q[DESC_WIDTH-1:0]] <= crc_ok;
        end
    end

    // State register for both FSMs, pointers, counters and output stage.
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_q    <= W_IDLE;
            r_state_q    <= R_IDLE;
            wr_spec_q    <= '0;
            wr_commit_q  <= '0;
            rd_ptr_q     <= '0;
            len_q        <= '0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
            desc_wp_q    <= '0;
            desc_rp_q    <= '0;
            rem_q        <= '0;
            crc_q        <= 1'b0;
            out_octet_q  <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_crc_q    <= 1'b0;
        end else begin
            w_state_q    <= w_state_d;
            r_state_q    <= r_state_d;
            wr_spec_q    <= wr_spec_d;
            wr_commit_q  <= wr_commit_d;
            rd_ptr_q     <= rd_ptr_d;
            len_q        <= len_d;
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
            desc_wp_q    <= desc_wp_d;
            desc_rp_q    <= desc_rp_d;
            rem_q        <= rem_d;
            crc_q        <= crc_d;
            out_octet_q  <= out_octet_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_crc_q    <= out_crc_d;
        end
    end

    assign out_if.out_octet  = out_octet_q;
    assign out_if.out_valid  = out_valid_q;
    assign out_if.out_last   = out_last_q;
    assign out_if.out_crc_ok = out_crc_q;
    assign pkt_count         = pkt_count_q;
    assign drop_count        = drop_count_q;

endmodule
